rv_trace_buffer: RTL and testbench
==================================

Name: rv_trace_buffer

Overview:
- Hardware commit-trace capture stage; sits directly downstream of rv_pipelined's retire/trace port (update/pc/instr/reg/mem outputs).
- Classifies each retired instruction into a compact record and buffers it in a FIFO, drained over a valid/ready port.
- Maintains retired-instruction and cycle counters and detects program end (instr == 0), so trace and CPI are available in-system and not only in simulation.

Parameters:
- XLEN, 32, datapath width of pc/instr/data/address fields.
- DEPTH, 16, FIFO entries; power of two, >= 2.
- CNT_W, 32, width of instr_cnt_o / cycle_cnt_o / drop_cnt_o.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- en_i  in  1  start capture (level); sampled in IDLE.
- clear_i  in  1  one-cycle pulse: DONE -> IDLE, zero counters and flags.
- update_i  in  1  core retires pc_i/instr_i this cycle.
- pc_i, instr_i  in  XLEN  retired pc / instruction word.
- reg_addr_i  in  5  destination register.
- reg_data_i  in  XLEN  writeback value.
- mem_addr_i, mem_data_i  in  XLEN  memory address / store data.
- trace_valid_o  out  1  head record valid.
- trace_ready_i  in  1  consumer accepts head record.
- trace_kind_o  out  2  0=REG, 1=LOAD, 2=STORE, 3=NONE.
- trace_pc_o, trace_instr_o  out  XLEN  record pc / instr.
- trace_rd_o  out  5  rd (0 for STORE/NONE).
- trace_data_o  out  XLEN  REG/LOAD: reg_data; STORE: masked mem_data; NONE: 0.
- trace_addr_o  out  XLEN  LOAD/STORE: mem_addr; otherwise 0.
- instr_cnt_o, cycle_cnt_o, drop_cnt_o  out  CNT_W  counters.
- done_o  out  1  end detected and FIFO drained.
- overflow_o  out  1  sticky; at least one record dropped.

Behaviour:
- Reset: state IDLE, FIFO empty, trace_valid_o=0, all trace_* data outputs 0, all counters 0, done_o=0, overflow_o=0.
- FSM:
  - IDLE -> RUN when en_i=1.
  - RUN -> DRAIN in the first cycle instr_i == 0. That cycle is neither counted nor captured, even if update_i=1.
  - DRAIN -> DONE when FIFO is empty (same cycle if already empty).
  - DONE -> IDLE on clear_i. clear_i is ignored in all other states.
- RUN, instr_i != 0: cycle_cnt +1 every cycle. If update_i: instr_cnt +1 and push one record.
- Classification on instr_i[6:0]:
  - 0100011 -> STORE. funct3 000: data={0,mem_data[7:0]}; 001: {0,mem_data[15:0]}; 010: full word; other funct3: full word.
  - 0000011 -> LOAD.
  - 1100011, or reg_addr_i == 0 -> NONE.
  - Otherwise REG.
- FIFO is first-word-fall-through: trace_* reflect the head entry whenever trace_valid_o=1. Pop on trace_valid_o & trace_ready_i.
- Latency: record pushed at edge N is visible at trace_valid_o after edge N (1 cycle).
- Full: push with FIFO full and no pop in the same cycle -> record dropped, drop_cnt +1, overflow_o set. instr_cnt still increments.
- Full with simultaneous pop: push accepted, no drop.
- Counters saturate at all-ones; no wrap.
- Draining continues in DRAIN and DONE states. Outputs are held stable while valid & !ready.
- done_o = 1 exactly while in DONE.
- rst_i mid-operation: immediate asynchronous return to reset values; FIFO contents discarded.

Optional Feature:
- Macro: TRACE_CPI_EN.
- Defined: adds outputs cpi_o (32-bit, Q16.16) and cpi_valid_o.
  - On entering DONE, a sequential shift-subtract divider computes (cycle_cnt << 16) / instr_cnt, one quotient bit per cycle (CNT_W+16 cycles). cpi_valid_o then rises and holds until clear_i/reset.
  - instr_cnt == 0 -> cpi_o = 0xFFFFFFFF, valid 1 cycle after DONE entry.
  - Quotient wider than 32 bits saturates to 0xFFFFFFFF.
- Undefined: cpi_o and cpi_valid_o tied to 0; no divider logic.

Test Plan:
- Retire addi x5 (0x00500293, pc 0x0, data 5), consumer ready=1 -> one REG record: rd=5, data=0x5, addr=0; instr_cnt=1.
- sb with mem_data=0xDEADBEEF, mem_addr=0x100 -> STORE record, data=0x000000EF, addr=0x100, rd=0. sh -> data 0x0000BEEF.
- trace_ready_i=0, DEPTH+3=19 retires -> 16 records buffered, drop_cnt=3, overflow_o=1. A 17th push in the same cycle as a pop is not dropped.
- 10 RUN cycles with 4 updates, then instr_i=0 with update_i=1 -> cycle_cnt=10, instr_cnt=4, DRAIN; done_o rises after the last pop.
- rst_i asserted mid-RUN with 5 entries queued -> trace_valid_o=0 and counters 0 asynchronously; FSM in IDLE.
- TRACE_CPI_EN: cycle_cnt=10, instr_cnt=4 -> cpi_o=0x00028000 with cpi_valid_o=1. instr_cnt=0 -> cpi_o=0xFFFFFFFF.

Source files
------------

// File: rtl/rv_trace_buffer.sv
// Commit-trace capture: classifies retired instructions into records, buffers them in a
// FWFT FIFO and keeps instr/cycle/drop counters. Define TRACE_CPI_EN for the CPI divider.
//
// state | meaning
// IDLE  | waiting for en_i
// RUN   | capturing retires until instr_i == 0
// DRAIN | end seen, waiting for the FIFO to empty
// DONE  | drained; counters frozen until clear_i
module rv_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clear_i,
    input  logic             update_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  instr_i,
    input  logic [4:0]       reg_addr_i,
    input  logic [XLEN-1:0]  reg_data_i,
    input  logic [XLEN-1:0]  mem_addr_i,
    input  logic [XLEN-1:0]  mem_data_i,
    output logic             trace_valid_o,
    input  logic             trace_ready_i,
    output logic [1:0]       trace_kind_o,
    output logic [XLEN-1:0]  trace_pc_o,
    output logic [XLEN-1:0]  trace_instr_o,
    output logic [4:0]       trace_rd_o,
    output logic [XLEN-1:0]  trace_data_o,
    output logic [XLEN-1:0]  trace_addr_o,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o,
    output logic             done_o,
    output logic             overflow_o,
    output logic [31:0]      cpi_o,
    output logic             cpi_valid_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    localparam logic [1:0] KIND_REG   = 2'd0;
    localparam logic [1:0] KIND_LOAD  = 2'd1;
    localparam logic [1:0] KIND_STORE = 2'd2;
    localparam logic [1:0] KIND_NONE  = 2'd3;

    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [1:0]      kind;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] addr;
    } rec_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t           state;
    rec_t             mem [DEPTH];
    rec_t             rec;
    rec_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] count;
    logic             empty;
    logic             full;
    logic             live;
    logic             push_req;
    logic             push_ok;
    logic             drop;
    logic             pop;

    always_comb begin
        rec       = '0;
        rec.pc    = pc_i;
        rec.instr = instr_i;
        if (instr_i[6:0] == OP_STORE) begin
            rec.kind = KIND_STORE;
            rec.addr = mem_addr_i;
            unique case (instr_i[14:12])
                3'b000:  rec.data = XLEN'(mem_data_i[7:0]);
                3'b001:  rec.data = XLEN'(mem_data_i[15:0]);
                default: rec.data = mem_data_i;
            endcase
        end else if (instr_i[6:0] == OP_LOAD) begin
            rec.kind = KIND_LOAD;
            rec.rd   = reg_addr_i;
            rec.data = reg_data_i;
            rec.addr = mem_addr_i;
        end else if (instr_i[6:0] == OP_BRANCH || reg_addr_i == 5'd0) begin
            rec.kind = KIND_NONE;
        end else begin
            rec.kind = KIND_REG;
            rec.rd   = reg_addr_i;
            rec.data = reg_data_i;
        end
    end

    assign count    = wr_ptr - rd_ptr;
    assign empty    = (count == '0);
    assign full     = (count == PTR_W'(DEPTH));
    assign live     = (state == RUN) && (instr_i != '0);
    assign push_req = live && update_i;
    assign pop      = trace_valid_o && trace_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= rec;
        end
    end

    assign head          = mem[rd_ptr[AW-1:0]];
    assign trace_valid_o = !empty;
    assign trace_kind_o  = trace_valid_o ? head.kind  : 2'd0;
    assign trace_pc_o    = trace_valid_o ? head.pc    : '0;
    assign trace_instr_o = trace_valid_o ? head.instr : '0;
    assign trace_rd_o    = trace_valid_o ? head.rd    : 5'd0;
    assign trace_data_o  = trace_valid_o ? head.data  : '0;
    assign trace_addr_o  = trace_valid_o ? head.addr  : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            instr_cnt_o <= '0;
            cycle_cnt_o <= '0;
            drop_cnt_o  <= '0;
            overflow_o  <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (live) begin
                cycle_cnt_o <= sat_inc(cycle_cnt_o);
                if (update_i) begin
                    instr_cnt_o <= sat_inc(instr_cnt_o);
                end
            end
            if (drop) begin
                drop_cnt_o <= sat_inc(drop_cnt_o);
                overflow_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (en_i) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (instr_i == '0) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (empty) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
                DONE: begin
                    if (clear_i) begin
                        state       <= IDLE;
                        done_o      <= 1'b0;
                        instr_cnt_o <= '0;
                        cycle_cnt_o <= '0;
                        drop_cnt_o  <= '0;
                        overflow_o  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TRACE_CPI_EN
    localparam int QW = CNT_W + 16;
    localparam int BW = $clog2(QW + 1);
    localparam logic [QW-1:0] QMAX = QW'(64'hFFFF_FFFF);

    logic [QW-1:0]    quo;
    logic [QW-1:0]    quo_nx;
    logic [CNT_W:0]   rem;
    logic [CNT_W:0]   rem_sh;
    logic [CNT_W-1:0] divisor;
    logic [BW-1:0]    bits_left;
    logic             div_busy;
    logic             div_started;
    logic             take;

    // Restoring division: one quotient bit per cycle, MSB first.
    assign rem_sh = {rem[CNT_W-1:0], quo[QW-1]};
    assign take   = (rem_sh >= {1'b0, divisor});
    assign quo_nx = {quo[QW-2:0], take};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            quo         <= '0;
            rem         <= '0;
            divisor     <= '0;
            bits_left   <= '0;
            div_busy    <= 1'b0;
            div_started <= 1'b0;
            cpi_o       <= '0;
            cpi_valid_o <= 1'b0;
        end else if (state == DONE && clear_i) begin
            quo         <= '0;
            rem         <= '0;
            divisor     <= '0;
            bits_left   <= '0;
            div_busy    <= 1'b0;
            div_started <= 1'b0;
            cpi_o       <= '0;
            cpi_valid_o <= 1'b0;
        end else if (state == DONE && !div_started) begin
            div_started <= 1'b1;
            if (instr_cnt_o == '0) begin
                cpi_o       <= 32'hFFFF_FFFF;
                cpi_valid_o <= 1'b1;
            end else begin
                quo       <= {cycle_cnt_o, 16'h0000};
                rem       <= '0;
                divisor   <= instr_cnt_o;
                bits_left <= BW'(QW);
                div_busy  <= 1'b1;
            end
        end else if (div_busy) begin
            rem       <= take ? rem_sh - {1'b0, divisor} : rem_sh;
            quo       <= quo_nx;
            bits_left <= bits_left - BW'(1);
            if (bits_left == BW'(1)) begin
                div_busy    <= 1'b0;
                cpi_valid_o <= 1'b1;
                cpi_o       <= (quo_nx > QMAX) ? 32'hFFFF_FFFF : 32'(quo_nx);
            end
        end
    end
`else
    assign cpi_o       = '0;
    assign cpi_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_rv_trace_buffer.sv
// Bench for rv_trace_buffer: directed retire sequences plus random traffic, compared each
// cycle against a queue-based model of the trace FIFO, counters and run phases.
module tb_rv_trace_buffer;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] addr;
    } rec_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic        clr;
    logic        upd;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rad;
    logic [31:0] rdata;
    logic [31:0] maddr;
    logic [31:0] mdata;
    logic        rdy;
    logic        trace_valid_o;
    logic [1:0]  trace_kind_o;
    logic [31:0] trace_pc_o;
    logic [31:0] trace_instr_o;
    logic [4:0]  trace_rd_o;
    logic [31:0] trace_data_o;
    logic [31:0] trace_addr_o;
    logic [31:0] instr_cnt_o;
    logic [31:0] cycle_cnt_o;
    logic [31:0] drop_cnt_o;
    logic        done_o;
    logic        overflow_o;
    logic [31:0] cpi_o;
    logic        cpi_valid_o;

    int checks = 0;
    int errors = 0;

    // model: phase 0 idle, 1 capturing, 2 draining, 3 finished
    rec_t        q[$];
    int          mode;
    int unsigned m_cyc;
    int unsigned m_icnt;
    int unsigned m_drop;
    bit          m_ovf;

    rv_trace_buffer #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .update_i(upd),
        .pc_i(pc), .instr_i(instr), .reg_addr_i(rad), .reg_data_i(rdata),
        .mem_addr_i(maddr), .mem_data_i(mdata),
        .trace_valid_o(trace_valid_o), .trace_ready_i(rdy),
        .trace_kind_o(trace_kind_o), .trace_pc_o(trace_pc_o),
        .trace_instr_o(trace_instr_o), .trace_rd_o(trace_rd_o),
        .trace_data_o(trace_data_o), .trace_addr_o(trace_addr_o),
        .instr_cnt_o(instr_cnt_o), .cycle_cnt_o(cycle_cnt_o), .drop_cnt_o(drop_cnt_o),
        .done_o(done_o), .overflow_o(overflow_o),
        .cpi_o(cpi_o), .cpi_valid_o(cpi_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t expect_rec();
        rec_t r;
        logic [2:0] f3;
        r = '0;
        r.pc = pc;
        r.instr = instr;
        f3 = instr[14:12];
        if (instr[6:0] == 7'h23) begin
            r.kind = 2'd2;
            r.addr = maddr;
            r.data = (f3 == 3'd0) ? (mdata & 32'h0000_00FF) :
                     (f3 == 3'd1) ? (mdata & 32'h0000_FFFF) : mdata;
        end else if (instr[6:0] == 7'h03) begin
            r.kind = 2'd1;
            r.rd   = rad;
            r.data = rdata;
            r.addr = maddr;
        end else if (instr[6:0] == 7'h63 || rad == 5'd0) begin
            r.kind = 2'd3;
        end else begin
            r.kind = 2'd0;
            r.rd   = rad;
            r.data = rdata;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37};
        logic [31:0] w;
        w = $urandom();
        w[6:0] = ops[$urandom_range(0, 5)];
        return w;
    endfunction

    task automatic rand_retire();
        pc    = $urandom();
        instr = rand_instr();
        rad   = 5'($urandom_range(0, 31));
        rdata = $urandom();
        maddr = $urandom();
        mdata = $urandom();
    endtask

    task automatic model_reset();
        q.delete();
        mode   = 0;
        m_cyc  = 0;
        m_icnt = 0;
        m_drop = 0;
        m_ovf  = 1'b0;
    endtask

    // Compare DUT to the model, advance the model by one clock using the current inputs.
    task automatic step();
        rec_t r;
        int   n0;
        check("valid", trace_valid_o, q.size() != 0);
        if (q.size() != 0) begin
            check("kind", trace_kind_o, q[0].kind);
            check("pc", trace_pc_o, q[0].pc);
            check("instr", trace_instr_o, q[0].instr);
            check("rd", trace_rd_o, q[0].rd);
            check("data", trace_data_o, q[0].data);
            check("addr", trace_addr_o, q[0].addr);
        end
        check("instr_cnt", instr_cnt_o, m_icnt);
        check("cycle_cnt", cycle_cnt_o, m_cyc);
        check("drop_cnt", drop_cnt_o, m_drop);
        check("overflow", overflow_o, m_ovf);
        check("done", done_o, mode == 3);
        n0 = q.size();
        if (n0 != 0 && rdy) r = q.pop_front();
        if (mode == 1 && instr != 0) begin
            if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
            if (upd) begin
                if (m_icnt != 32'hFFFF_FFFF) m_icnt++;
                if (q.size() < DEPTH) q.push_back(expect_rec());
                else begin
                    if (m_drop != 32'hFFFF_FFFF) m_drop++;
                    m_ovf = 1'b1;
                end
            end
        end
        case (mode)
            0: if (en) mode = 1;
            1: if (instr == 0) mode = 2;
            2: if (n0 == 0) mode = 3;
            3: if (clr) begin
                mode = 0; m_cyc = 0; m_icnt = 0; m_drop = 0; m_ovf = 1'b0;
            end
            default: mode = 0;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic drain_to_done();
        instr = 32'h0;
        upd   = 1'b0;
        rdy   = 1'b1;
        for (int i = 0; i < DEPTH + 8 && mode != 3; i++) step();
        check("reach_done", done_o, 1'b1);
    endtask

    task automatic check_cpi();
        logic [63:0] e;
`ifdef TRACE_CPI_EN
        if (m_icnt == 0) e = 64'hFFFF_FFFF;
        else begin
            e = ({32'h0, m_cyc} * 64'd65536) / m_icnt;
            if (e > 64'hFFFF_FFFF) e = 64'hFFFF_FFFF;
        end
        for (int i = 0; i < 120 && !cpi_valid_o; i++) step();
        check("cpi_valid", cpi_valid_o, 1'b1);
        check("cpi", cpi_o, e);
`else
        e = 64'h0;
        step();
        check("cpi_tied", cpi_o, e);
        check("cpi_valid_tied", cpi_valid_o, 1'b0);
`endif
    endtask

    task automatic do_clear();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_icnt", instr_cnt_o, 0);
        check("clr_done", done_o, 1'b0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; upd = 1'b0; rdy = 1'b1;
        pc = '0; instr = '0; rad = '0; rdata = '0; maddr = '0; mdata = '0;
        model_reset();
        #2;
        check("rst_valid", trace_valid_o, 1'b0);
        check("rst_kind", trace_kind_o, 2'd0);
        check("rst_data", trace_data_o, 32'h0);
        check("rst_addr", trace_addr_o, 32'h0);
        check("rst_cnts", {instr_cnt_o, cycle_cnt_o}, 64'h0);
        check("rst_drop", drop_cnt_o, 32'h0);
        check("rst_flags", {done_o, overflow_o}, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed run: 10 capture cycles, 4 retires, then end marker with update set.
        en = 1'b1; instr = 32'h13;
        step();
        upd = 1'b1; instr = 32'h0050_0293; pc = 32'h0; rad = 5'd5; rdata = 32'h5;
        step();
        check("addi_kind", trace_kind_o, 2'd0);
        check("addi_rd", trace_rd_o, 5'd5);
        check("addi_data", trace_data_o, 32'h5);
        check("addi_addr", trace_addr_o, 32'h0);
        check("addi_icnt", instr_cnt_o, 32'd1);
        instr = 32'h00A1_0023; pc = 32'h4; maddr = 32'h100; mdata = 32'hDEAD_BEEF;
        step();
        check("sb_kind", trace_kind_o, 2'd2);
        check("sb_data", trace_data_o, 32'h0000_00EF);
        check("sb_addr", trace_addr_o, 32'h100);
        check("sb_rd", trace_rd_o, 5'd0);
        instr = 32'h00A1_1023; pc = 32'h8;
        step();
        check("sh_data", trace_data_o, 32'h0000_BEEF);
        upd = 1'b0; instr = 32'h13;
        step();
        upd = 1'b1; instr = 32'h0001_2303; pc = 32'h10; rad = 5'd6; rdata = 32'h1234;
        maddr = 32'h200; rdy = 1'b0;
        step();
        check("lw_kind", trace_kind_o, 2'd1);
        check("lw_data", trace_data_o, 32'h1234);
        upd = 1'b0; instr = 32'h13;
        for (int i = 0; i < 5; i++) step();
        instr = 32'h0; upd = 1'b1;
        step();
        check("end_cyc", cycle_cnt_o, 32'd10);
        check("end_icnt", instr_cnt_o, 32'd4);
        check("drain_hold", done_o, 1'b0);
        drain_to_done();
        check("done_empty", trace_valid_o, 1'b0);
        check_cpi();
        do_clear();

        // Overflow: consumer stalled for DEPTH+3 retires, then a push alongside a pop.
        en = 1'b1; rdy = 1'b0;
        step();
        upd = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) begin
            rand_retire();
            step();
        end
        check("ovf_drop", drop_cnt_o, 32'd3);
        check("ovf_flag", overflow_o, 1'b1);
        rdy = 1'b1;
        rand_retire();
        step();
        check("full_pop_drop", drop_cnt_o, 32'd3);
        check("full_pop_icnt", instr_cnt_o, 32'd20);

        // Random traffic, with stray clear pulses that must be ignored outside DONE.
        for (int i = 0; i < 250; i++) begin
            rand_retire();
            upd = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            en  = 1'($urandom_range(0, 1));
            step();
        end
        clr = 1'b0;
        drain_to_done();
        check_cpi();
        do_clear();

        // Immediate end: no retires at all.
        en = 1'b1; instr = 32'h13; upd = 1'b0;
        step();
        drain_to_done();
        check("zero_icnt", instr_cnt_o, 32'd0);
        check_cpi();
        do_clear();

        // Asynchronous reset with entries queued.
        en = 1'b1; rdy = 1'b0; instr = 32'h13;
        step();
        upd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_retire();
            step();
        end
        check("pre_rst_valid", trace_valid_o, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid", trace_valid_o, 1'b0);
        check("arst_icnt", instr_cnt_o, 32'd0);
        check("arst_cyc", cycle_cnt_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        en = 1'b0; upd = 1'b1;
        rand_retire();
        step();
        step();
        check("idle_after_rst", cycle_cnt_o, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
